// File: rtl/approx_mul8_rr_sched_pkg.sv
// Shared constants, operand/product types and the round-robin pick function
// for the approximate-multiplier scheduler.
package approx_mul_pkg;

    localparam int OPW    = 8;
    localparam int PW     = 16;
    localparam int LROWS  = 2;
    localparam int MAXREQ = 16;

    typedef logic [OPW-1:0] op_t;
    typedef logic [PW-1:0]  prod_t;

    // Unused requester slots must be zero in valid; the 4-bit index wraps mod 16,
    // which visits ptr+1 .. NREQ-1, the empty slots, then 0 .. ptr.
    function automatic logic [3:0] next_rr(input logic [3:0] ptr,
                                           input logic [MAXREQ-1:0] valid);
        logic [3:0] idx;
        logic [3:0] pick;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= MAXREQ; k++) begin
            idx = ptr + 4'(k);
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/approx_mul8_rr_sched_if.sv
// Request/result bundle between the operand queues, the scheduler and the accumulate stage.
// APPROX_MUL_EXACT_BYPASS_EN adds the per-request exact-mode bit and its result flag.
interface approx_mul8_rr_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    import approx_mul_pkg::*;

    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*OPW-1:0] req_x;
    logic [NREQ*OPW-1:0] req_y;
    logic                res_valid;
    logic                res_ready;
    prod_t               res_z;
    logic [IDW-1:0]      res_id;
`ifdef APPROX_MUL_EXACT_BYPASS_EN
    logic [NREQ-1:0]     req_exact;
    logic                res_exact;

    modport master (output req_valid, req_x, req_y, req_exact, res_ready,
                    input  req_ready, res_valid, res_z, res_id, res_exact);
    modport slave  (input  req_valid, req_x, req_y, req_exact, res_ready,
                    output req_ready, res_valid, res_z, res_id, res_exact);
`else
    modport master (output req_valid, req_x, req_y, res_ready,
                    input  req_ready, res_valid, res_z, res_id);
    modport slave  (input  req_valid, req_x, req_y, res_ready,
                    output req_ready, res_valid, res_z, res_id);
`endif

endinterface

// File: rtl/approx_mul8_rr_sched_l2.sv
// Combinational 8x8 unsigned approximate multiplier: the two low partial-product
// rows are compressed into three columns, their bits below column 6 are dropped.
module approx_mul8_l2
    import approx_mul_pkg::*;
(
    input  op_t   x,
    input  op_t   y,
    output prod_t z
);

    logic p0_5, p0_6, p0_7;
    logic p1_4, p1_5, p1_6, p1_7;
    logic [2:0] col_a;
    logic [2:0] col_b;

    assign p0_5 = y[5] & x[0];
    assign p0_6 = y[6] & x[0];
    assign p0_7 = y[7] & x[0];
    assign p1_4 = y[4] & x[1];
    assign p1_5 = y[5] & x[1];
    assign p1_6 = y[6] & x[1];
    assign p1_7 = y[7] & x[1];

    // Carry-like and sum-like vectors of the compressed rows, both anchored at column 6
    assign col_a = {p0_7 & p1_6, p0_5 & p1_5, p0_6 | p1_4};
    assign col_b = {p1_7, p0_7 ^ p1_6, p0_5 ^ p1_5};

    assign z = ((prod_t'(y) * prod_t'(x[OPW-1:LROWS])) << LROWS)
             + (prod_t'(col_a) << 6)
             + (prod_t'(col_b) << 6);

endmodule

// File: rtl/approx_mul8_rr_sched.sv
// Round-robin scheduler sharing one two-stage approximate multiplier among NREQ requesters.
// APPROX_MUL_EXACT_BYPASS_EN lets a request select the exact product instead.
module approx_mul8_rr_sched
    import approx_mul_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
)(
    input logic                   clk,
    input logic                   rst_n,
    approx_mul8_rr_sched_if.slave bus
);

    logic           adv1, adv2, grant_any;
    logic [3:0]     gidx;
    logic [NREQ-1:0] ready;
    logic [IDW-1:0] ptr;
    op_t            x_sel, y_sel;

    logic           vld_p1;
    logic [IDW-1:0] id_p1;
    op_t            x_p1, y_p1;
    prod_t          approx_p1, prod_p1;

    logic           vld_p2;
    logic [IDW-1:0] id_p2;
    prod_t          z_p2;

    assign adv2      = !vld_p2 || bus.res_ready;
    assign adv1      = !vld_p1 || adv2;
    assign gidx      = next_rr(4'(ptr), 16'(bus.req_valid));
    assign grant_any = adv1 && (|bus.req_valid);

    always_comb begin
        ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            ready[i] = grant_any && (gidx == 4'(i));
        end
    end

    assign bus.req_ready = ready;
    assign x_sel = bus.req_x[OPW*int'(gidx[IDW-1:0]) +: OPW];
    assign y_sel = bus.req_y[OPW*int'(gidx[IDW-1:0]) +: OPW];

    // Stage 1: operand capture
    always_ff @(posedge clk) begin
        if (grant_any) begin
            x_p1 <= x_sel;
            y_p1 <= y_sel;
        end
    end

    approx_mul8_l2 u_mul (
        .x (x_p1),
        .y (y_p1),
        .z (approx_p1)
    );

`ifdef APPROX_MUL_EXACT_BYPASS_EN
    logic exact_p1;
    logic exact_p2;

    always_ff @(posedge clk) begin
        if (grant_any) begin
            exact_p1 <= bus.req_exact[gidx[IDW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exact_p2 <= 1'b0;
        end else if (adv2 && vld_p1) begin
            exact_p2 <= exact_p1;
        end
    end

    assign prod_p1       = exact_p1 ? prod_t'(x_p1) * prod_t'(y_p1) : approx_p1;
    assign bus.res_exact = exact_p2;
`else
    assign prod_p1 = approx_p1;
`endif

    // Stage 2: product register feeding the result port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            id_p1  <= '0;
            ptr    <= IDW'(NREQ - 1);
            vld_p2 <= 1'b0;
            id_p2  <= '0;
            z_p2   <= '0;
        end else begin
            if (adv1) begin
                vld_p1 <= grant_any;
                if (grant_any) begin
                    id_p1 <= gidx[IDW-1:0];
                    ptr   <= gidx[IDW-1:0];
                end
            end
            if (adv2) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    z_p2  <= prod_p1;
                    id_p2 <= id_p1;
                end
            end
        end
    end

    assign bus.res_valid = vld_p2;
    assign bus.res_z     = z_p2;
    assign bus.res_id    = id_p2;

endmodule

// File: tb/tb_approx_mul8_rr_sched.sv
// Directed bench for approx_mul8_rr_sched: reset, single requests, round-robin,
// backpressure, asynchronous reset mid-stream, and the exact bypass when enabled.
module tb_approx_mul8_rr_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Requester i uses x = 4*(i+1), y = 10+i; x[1:0]=0 so the product is exact.
    int   exp_z [4] = '{40, 88, 144, 208};

    approx_mul8_rr_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    approx_mul8_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] x, input logic [7:0] y);
        bus.req_x[i*8 +: 8] = x;
        bus.req_y[i*8 +: 8] = y;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.res_ready = 1'b1;
`ifdef APPROX_MUL_EXACT_BYPASS_EN
        bus.req_exact = '0;
`endif
        rst_n = 1'b0;
        repeat (2) tick();
        check("rst_res_valid", 32'(bus.res_valid), 0);
        check("rst_res_z", 32'(bus.res_z), 0);
        check("rst_res_id", 32'(bus.res_id), 0);
        rst_n = 1'b1;

        // single request: x=3, y=255 -> approximate 704
        set_op(0, 8'd3, 8'd255);
        bus.req_valid = 4'b0001;
        #1;
        check("first_grant", 32'(bus.req_ready), 1);
        tick();
        bus.req_valid = '0;
        check("s1_only_no_result", 32'(bus.res_valid), 0);
        tick();
        check("single_valid", 32'(bus.res_valid), 1);
        check("single_z", 32'(bus.res_z), 704);
        check("single_id", 32'(bus.res_id), 0);
        tick();
        check("single_drained", 32'(bus.res_valid), 0);

        // exact-path value from requester 2
        set_op(2, 8'd4, 8'd5);
        bus.req_valid = 4'b0100;
        #1;
        check("req2_grant", 32'(bus.req_ready), 4);
        tick();
        bus.req_valid = '0;
        tick();
        check("req2_z", 32'(bus.res_z), 20);
        check("req2_id", 32'(bus.res_id), 2);
        tick();

`ifdef APPROX_MUL_EXACT_BYPASS_EN
        set_op(0, 8'd3, 8'd255);
        bus.req_exact = 4'b0001;
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = '0;
        tick();
        check("bypass_z", 32'(bus.res_z), 765);
        check("bypass_flag", 32'(bus.res_exact), 1);
        bus.req_exact = '0;
        tick();
        check("bypass_drained", 32'(bus.res_valid), 0);
`endif

        // round-robin from a fresh pointer
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, 8'(4 * (i + 1)), 8'(10 + i));
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("rr_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
            @(posedge clk);
            #1;
            if (k == 0) begin
                check("rr_first_empty", 32'(bus.res_valid), 0);
            end else begin
                check("rr_valid", 32'(bus.res_valid), 1);
                check("rr_id", 32'(bus.res_id), 32'((k - 1) % 4));
                check("rr_z", 32'(bus.res_z), 32'(exp_z[(k - 1) % 4]));
            end
        end
        bus.req_valid = '0;
        tick();
        check("rr_tail_id", 32'(bus.res_id), 3);
        check("rr_tail_z", 32'(bus.res_z), 208);
        tick();
        check("rr_empty", 32'(bus.res_valid), 0);

        // backpressure: two accepts fill S1/S2, then grants stop
        bus.res_ready = 1'b0;
        bus.req_valid = 4'b1111;
        #1;
        check("bp_grant0", 32'(bus.req_ready), 1);
        tick();
        check("bp_grant1", 32'(bus.req_ready), 2);
        tick();
        for (int c = 0; c < 3; c++) begin
            check("bp_no_grant", 32'(bus.req_ready), 0);
            check("bp_hold_valid", 32'(bus.res_valid), 1);
            check("bp_hold_z", 32'(bus.res_z), 40);
            check("bp_hold_id", 32'(bus.res_id), 0);
            tick();
        end
        check("bp_still_blocked", 32'(bus.req_ready), 0);
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        tick();
        check("bp_drain_valid", 32'(bus.res_valid), 1);
        check("bp_drain_z", 32'(bus.res_z), 88);
        check("bp_drain_id", 32'(bus.res_id), 1);
        tick();
        check("bp_drain_empty", 32'(bus.res_valid), 0);

        // asynchronous reset with both stages full
        bus.res_ready = 1'b0;
        bus.req_valid = 4'b1111;
        tick();
        tick();
        check("mid_full_valid", 32'(bus.res_valid), 1);
        check("mid_full_id", 32'(bus.res_id), 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.res_valid), 0);
        check("mid_rst_z", 32'(bus.res_z), 0);
        check("mid_rst_id", 32'(bus.res_id), 0);
        #1;
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        #1;
        check("post_rst_grant", 32'(bus.req_ready), 1);
        tick();
        tick();
        check("post_rst_valid", 32'(bus.res_valid), 1);
        check("post_rst_id", 32'(bus.res_id), 0);
        check("post_rst_z", 32'(bus.res_z), 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/approx_mul8_rr_sched.md
Name: approx_mul8_rr_sched

Overview:
- Shares one registered 8x8 unsigned approximate multiplier (l=2 low-row compression) among NREQ requesters.
- Round-robin arbitration, valid/ready on every request port and on the single result port.
- Two-stage pipeline: operand register S1, product register S2. Each result carries the ID of the requester that issued it.
- Sits between the accelerator's operand queues and its accumulate stage.

Parameters:
- NREQ, 4, number of requesters (2..16)
- IDW, 2, requester ID width; must equal clog2(NREQ)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  request i holds operands valid
- req_x  input  NREQ*8  operand x of requester i in bits [8i+7:8i]
- req_y  input  NREQ*8  operand y of requester i, same packing
- req_ready  output  NREQ  one-hot grant; transfer occurs when req_valid[i] and req_ready[i] are both high
- res_valid  output  1  res_z and res_id valid
- res_ready  input  1  consumer accepts result
- res_z  output  16  approximate product
- res_id  output  IDW  originating requester

Behaviour:
- Reset: asynchronous active-low, single clock domain.
  - Clears S1 valid, S2 valid (res_valid=0), res_z=0, res_id=0.
  - Sets rr pointer to NREQ-1, so requester 0 has top priority first.
  - Reset mid-operation discards all in-flight products. No partial result is emitted.
- Stall/advance:
  - adv2 = !res_valid | res_ready.
  - adv1 = !s1_valid | adv2.
- Arbitration (combinational):
  - Applies only when adv1=1.
  - Grant goes to the first i with req_valid[i], scanning from ptr+1 modulo NREQ.
  - req_ready is one-hot on that i and all-zero when adv1=0.
  - req_ready never depends on res_valid of the same cycle beyond adv2.
- On a grant:
  - S1 captures x, y and id.
  - ptr is set to the granted id.
  - ptr is unchanged when there is no grant.
- S1 to S2 on adv2: S2 loads the product of the S1 operands and s1_id. res_valid takes s1_valid.
- Latency and throughput:
  - Exactly 2 cycles from the accepting edge to res_valid, with no stall.
  - Throughput is one result per cycle.
  - Results leave in acceptance order.
  - Holding res_ready=0 freezes S2 and S1. Once S1 is full, all req_ready go low. No result is dropped or duplicated.
- Simultaneous events: res_ready=1 with S2 full and S1 full accepts a new request in the same cycle, so the pipeline moves fully.
- Approximate product, with p0 = y & {8{x[0]}} and p1 = y & {8{x[1]}}:
  - A = {p0[7]&p1[6], p0[5]&p1[5], p0[6]|p1[4]} << 6
  - B = {p1[7], p0[7]^p1[6], p0[5]^p1[5]} << 6
  - z = ((y * x[7:2]) << 2) + A + B, truncated to 16 bits.
  - Partial-product columns 0..5 of rows 0..1 are dropped.
- Output stability: res_z and res_id hold stable while res_valid=1 and res_ready=0.

Optional Feature:
- Macro: APPROX_MUL_EXACT_BYPASS_EN.
- When defined:
  - Adds input req_exact (NREQ bits). The bit is captured into S1 with the operands.
  - S2 loads the exact x*y when the captured bit is 1, else the approximate z.
  - Adds output res_exact (1 bit), reset 0, aligned with res_z.
- When undefined: the ports do not exist and every result is approximate.
- Latency and arbitration are identical in both builds.

Decomposition:
- Package approx_mul_pkg:
  - constants OPW=8, PW=16, LROWS=2
  - typedef op_t (logic [7:0]) and prod_t (logic [15:0])
  - function next_rr(ptr, valid) returning the granted index
- Sub-module approx_mul8_l2: purely combinational x, y to z as defined above. Instantiated once, between S1 and S2.
- The scheduler holds only the arbiter, pointer and pipeline registers.

Test Plan:
- Single request, requester 0 asserts x=3, y=255:
  - req_ready[0] is high on the first cycle after reset.
  - res_valid rises 2 cycles later with res_z=704 and res_id=0. The exact product would be 765.
- Exact-path value, x=4, y=5 from requester 2: res_z=20, res_id=2.
- All four requesters continuously valid, res_ready=1: grants follow 0,1,2,3,0,… with one result per cycle and res_id in the same order.
- Backpressure:
  - Hold res_ready=0 for 5 cycles with all requesters valid.
  - Exactly 2 requests are accepted, then req_ready=0. res_z/res_id stay stable.
  - After release, the results drain in order with no loss.
- Reset mid-stream: assert rst_n=0 while S1 and S2 are full. res_valid drops immediately and asynchronously. After release, requester 0 is granted first.
- With APPROX_MUL_EXACT_BYPASS_EN defined, x=3, y=255, req_exact=1: res_z=765, res_exact=1.
